// File: rtl/rst_seq.sv
// rst_seq: reset sequencer for the constant-reset flop stages.
// Synchronises the deassertion of the raw asynchronous reset and waits a
// settle period. It then releases NUM_OUT staged reset lines one at a time,
// STAGE_GAP cycles apart.
//
// Ports:
//   clk       in   single clock, rising edge
//   reset     in   asynchronous, active-high board reset
//   sw_rst    in   synchronous, active-high software reset (RST_SEQ_SWRST_EN only)
//   rst_out   out  [NUM_OUT-1:0] staged resets, active-high, bit 0 released first
//   rst_done  out  high once every rst_out bit is low
//
// Build option: define RST_SEQ_SWRST_EN to add the sw_rst port. A software
// reset re-enters HOLD directly and skips the synchroniser.
module rst_seq #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned NUM_OUT     = 4,
  parameter int unsigned STAGE_GAP   = 4
) (
  input  logic               clk,
  input  logic               reset,
`ifdef RST_SEQ_SWRST_EN
  input  logic               sw_rst,
`endif
  output logic [NUM_OUT-1:0] rst_out,
  output logic               rst_done
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = $clog2(NUM_OUT + 1);

  localparam logic [1:0] ST_SYNC  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_STAGE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_rst;
  logic [1:0]             state_q,     state_d;
  logic [CNT_W-1:0]       hold_cnt_q,  hold_cnt_d;
  logic [CNT_W-1:0]       stage_cnt_q, stage_cnt_d;
  logic [IDX_W-1:0]       idx_q,       idx_d;
  logic [NUM_OUT-1:0]     rst_out_q,   rst_out_d;
  logic                   rst_done_q,  rst_done_d;
  logic                   hold_tick;

  assign sync_rst = sync_q[SYNC_STAGES-1];
  assign rst_out  = rst_out_q;
  assign rst_done = rst_done_q;

  // Deassertion synchroniser: zeros shift in once reset is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SYNC;
      hold_cnt_q  <= '0;
      stage_cnt_q <= '0;
      idx_q       <= '0;
      rst_out_q   <= '1;
      rst_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      stage_cnt_q <= stage_cnt_d;
      idx_q       <= idx_d;
      rst_out_q   <= rst_out_d;
      rst_done_q  <= rst_done_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    stage_cnt_d = stage_cnt_q;
    idx_d       = idx_q;
    rst_out_d   = rst_out_q;
    rst_done_d  = rst_done_q;
    hold_tick   = 1'b0;

    case (state_q)
      // The edge that first sees sync_rst low already counts as hold cycle 1.
      ST_SYNC: hold_tick = ~sync_rst;
      ST_HOLD: hold_tick = 1'b1;
      ST_STAGE: begin
        if (idx_q == IDX_W'(NUM_OUT)) begin
          state_d    = ST_DONE;
          rst_done_d = 1'b1;
        end else begin
          stage_cnt_d = stage_cnt_q + CNT_W'(1);
          if (stage_cnt_d == CNT_W'(STAGE_GAP)) begin
            for (int k = 0; k < NUM_OUT; k++) begin
              if (IDX_W'(k) == idx_q) rst_out_d[k] = 1'b0;
            end
            idx_d       = idx_q + IDX_W'(1);
            stage_cnt_d = '0;
          end
        end
      end
      ST_DONE: begin
        rst_out_d  = '0;
        rst_done_d = 1'b1;
      end
      default: state_d = ST_SYNC;
    endcase

    // Hold period; its last cycle releases bit 0 and enters STAGE.
    if (hold_tick) begin
      state_d    = ST_HOLD;
      hold_cnt_d = hold_cnt_q + CNT_W'(1);
      if (hold_cnt_d == CNT_W'(HOLD_CYCLES)) begin
        rst_out_d[0] = 1'b0;
        idx_d        = IDX_W'(1);
        stage_cnt_d  = '0;
        hold_cnt_d   = '0;
        state_d      = ST_STAGE;
      end
    end

`ifdef RST_SEQ_SWRST_EN
    // Software reset re-arms every output and restarts the hold count.
    if (sw_rst) begin
      state_d     = ST_HOLD;
      hold_cnt_d  = '0;
      stage_cnt_d = '0;
      idx_d       = '0;
      rst_out_d   = '1;
      rst_done_d  = 1'b0;
    end
`else
`endif
  end

endmodule

// File: tb/tb_rst_seq.sv
module tb_rst_seq;

  logic       clk;
  logic       reset;
  logic       reset1;
  logic       sw_rst;
  logic [3:0] rst_out;
  logic       rst_done;
  logic [0:0] rst_out1;
  logic       rst_done1;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b1;
  always #10 clk = ~clk;

  rst_seq u_dut (
    .clk      (clk),
    .reset    (reset),
`ifdef RST_SEQ_SWRST_EN
    .sw_rst   (sw_rst),
`endif
    .rst_out  (rst_out),
    .rst_done (rst_done)
  );

  rst_seq #(.SYNC_STAGES(3), .HOLD_CYCLES(1), .NUM_OUT(1), .STAGE_GAP(4)) u_dut1 (
    .clk      (clk),
    .reset    (reset1),
`ifdef RST_SEQ_SWRST_EN
    .sw_rst   (1'b0),
`endif
    .rst_out  (rst_out1),
    .rst_done (rst_done1)
  );

  // Expected {rst_out (zero-extended to 16), rst_done} after edge n counted
  // from the start of a sequence. Bit k is still asserted before edge s+h+k*g;
  // done rises one edge after the last release.
  function automatic logic [16:0] exp_vec(int n, int s, int h, int g, int nout);
    logic [15:0] o;
    logic        d;
    o = '0;
    for (int k = 0; k < nout; k++) o[k] = (n < s + h + k * g);
    d = (n >= s + h + (nout - 1) * g + 1);
    return {o, d};
  endfunction

  task automatic test_reset();
    logic [16:0] obs;
    logic [16:0] ex;
    reset  = 1'b1;
    reset1 = 1'b1;
    sw_rst = 1'b0;
    ex = {16'h000F, 1'b0};
    repeat (2) begin
      @(posedge clk); #1;
      obs = {16'(rst_out), rst_done};
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL reset_state got out=%h done=%b exp out=%h done=%b",
                 obs[16:1], obs[0], ex[16:1], ex[0]);
      end
    end
    #9;
  endtask

  task automatic test_default_seq();
    logic [16:0] obs;
    logic [16:0] ex;
    reset = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      obs = {16'(rst_out), rst_done};
      ex  = exp_vec(n, 2, 16, 4, 4);
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL default_seq edge %0d got out=%h done=%b exp out=%h done=%b",
                 n, obs[16:1], obs[0], ex[16:1], ex[0]);
      end
    end
  endtask

  task automatic test_long_run();
    logic [16:0] obs;
    logic [16:0] ex;
    for (int n = 41; n <= 2040; n++) begin
      @(posedge clk); #1;
      obs = {16'(rst_out), rst_done};
      ex  = exp_vec(n, 2, 16, 4, 4);
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL long_run edge %0d got out=%h done=%b exp out=%h done=%b",
                 n, obs[16:1], obs[0], ex[16:1], ex[0]);
      end
    end
  endtask

  // Short asynchronous glitch while in DONE, then a full re-run.
  task automatic test_glitch(int unsigned offs);
    logic [16:0] obs;
    logic [16:0] ex;
    @(negedge clk);
    #(offs);
    reset = 1'b1;
    #1;
    obs = {16'(rst_out), rst_done};
    ex  = {16'h000F, 1'b0};
    checks++;
    if (obs !== ex) begin
      errors++;
      $display("FAIL glitch_async got out=%h done=%b exp out=%h done=%b",
               obs[16:1], obs[0], ex[16:1], ex[0]);
    end
    #2;
    reset = 1'b0;
    for (int n = 1; n <= 35; n++) begin
      @(posedge clk); #1;
      obs = {16'(rst_out), rst_done};
      ex  = exp_vec(n, 2, 16, 4, 4);
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL glitch_rerun edge %0d got out=%h done=%b exp out=%h done=%b",
                 n, obs[16:1], obs[0], ex[16:1], ex[0]);
      end
    end
  endtask

  // Reset re-asserted after edge `cut` of a fresh sequence, then released.
  task automatic test_mid_reset(int cut);
    logic [16:0] obs;
    logic [16:0] ex;
    @(negedge clk);
    reset = 1'b1;
    #3;
    reset = 1'b0;
    for (int n = 1; n <= cut; n++) begin
      @(posedge clk); #1;
      obs = {16'(rst_out), rst_done};
      ex  = exp_vec(n, 2, 16, 4, 4);
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL mid_first edge %0d got out=%h done=%b exp out=%h done=%b",
                 n, obs[16:1], obs[0], ex[16:1], ex[0]);
      end
    end
    #5;
    reset = 1'b1;
    #1;
    obs = {16'(rst_out), rst_done};
    ex  = {16'h000F, 1'b0};
    checks++;
    if (obs !== ex) begin
      errors++;
      $display("FAIL mid_async cut %0d got out=%h done=%b exp out=%h done=%b",
               cut, obs[16:1], obs[0], ex[16:1], ex[0]);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int n = 1; n <= 35; n++) begin
      @(posedge clk); #1;
      obs = {16'(rst_out), rst_done};
      ex  = exp_vec(n, 2, 16, 4, 4);
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL mid_rerun cut %0d edge %0d got out=%h done=%b exp out=%h done=%b",
                 cut, n, obs[16:1], obs[0], ex[16:1], ex[0]);
      end
    end
  endtask

  task automatic test_small_cfg();
    logic [16:0] obs;
    logic [16:0] ex;
    @(negedge clk);
    reset1 = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      obs = {16'(rst_out1), rst_done1};
      ex  = exp_vec(n, 3, 1, 4, 1);
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL small_cfg edge %0d got out=%h done=%b exp out=%h done=%b",
                 n, obs[16:1], obs[0], ex[16:1], ex[0]);
      end
    end
  endtask

`ifdef RST_SEQ_SWRST_EN
  // sw_rst high for `hi` edges, then the sequence measured from the first low sample.
  task automatic test_sw_rst(int hi);
    logic [16:0] obs;
    logic [16:0] ex;
    @(negedge clk);
    sw_rst = 1'b1;
    for (int i = 1; i <= hi; i++) begin
      @(posedge clk); #1;
      obs = {16'(rst_out), rst_done};
      ex  = {16'h000F, 1'b0};
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL sw_rst_high edge %0d got out=%h done=%b exp out=%h done=%b",
                 i, obs[16:1], obs[0], ex[16:1], ex[0]);
      end
    end
    @(negedge clk);
    sw_rst = 1'b0;
    for (int m = 1; m <= 32; m++) begin
      @(posedge clk); #1;
      obs = {16'(rst_out), rst_done};
      ex  = exp_vec(m, 0, 16, 4, 4);
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL sw_rst_seq edge %0d got out=%h done=%b exp out=%h done=%b",
                 m, obs[16:1], obs[0], ex[16:1], ex[0]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_default_seq();
    test_long_run();
    test_glitch(2);
    for (int i = 0; i < 3; i++) test_glitch($urandom_range(1, 6));
    test_mid_reset(24);
    for (int i = 0; i < 6; i++) test_mid_reset(int'($urandom_range(1, 34)));
    test_small_cfg();
`ifdef RST_SEQ_SWRST_EN
    test_sw_rst(3);
    test_sw_rst(int'($urandom_range(1, 5)));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
